// File: rtl/face_detect_div_pkg.sv
// Shared types and constants for the iterative signed/unsigned divider.
package face_detect_div_pkg;

  localparam int DIN0_WIDTH  = 32;
  localparam int DIV_LATENCY = DIN0_WIDTH + 2;

  localparam logic [31:0] QUOT_SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] QUOT_SAT_NEG = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/face_detect_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore.
module face_detect_div_step #(
  parameter int W = 14
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The MSB of diff is the borrow: set means the trial subtraction went negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/face_detect_sdiv_32s_14ns_iter.sv
// Iterative 32-bit signed / 14-bit unsigned divider, one quotient bit per enabled cycle.
// Define FACE_DETECT_DIV_REM_EN to build the signed remainder output; otherwise rem is 0.
module face_detect_sdiv_32s_14ns_iter
  import face_detect_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 0,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(din0_WIDTH);

  if (dout_WIDTH != din0_WIDTH || ID < 0 || NUM_STAGE < 0) begin : g_bad_params
    $error("face_detect_sdiv_32s_14ns_iter: dout_WIDTH must equal din0_WIDTH");
  end

  div_state_e            state, state_d;
  logic                  sign;
  logic                  zero;
  logic [din0_WIDTH-1:0] dvd;
  logic [din1_WIDTH-1:0] divisor;
  logic [din1_WIDTH:0]   part;
  logic [CNT_W-1:0]      cnt;
  logic [din1_WIDTH:0]   step_rem;
  logic                  step_q;

  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign done  = (state == S_DONE);

  face_detect_div_step #(.W(din1_WIDTH)) u_step (
    .rem_in  (part),
    .bit_in  (dvd[din0_WIDTH-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      S_IDLE, S_DONE: state_d = start ? S_PREP : S_IDLE;
      S_PREP:         state_d = S_CALC;
      S_CALC:         if (cnt == '0) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  state <= S_IDLE;
    else if (ce) state <= state_d;
  end

  // dvd doubles as the quotient: dividend bits shift out the top, quotient bits in at the bottom.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      sign     <= 1'b0;
      zero     <= 1'b0;
      dvd      <= '0;
      divisor  <= '0;
      part     <= '0;
      cnt      <= '0;
      dout     <= '0;
      div_zero <= 1'b0;
    end else if (ce) begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sign    <= din0[din0_WIDTH-1];
            dvd     <= din0[din0_WIDTH-1] ? -din0 : din0;
            divisor <= din1;
            zero    <= (din1 == '0);
          end
        end
        S_PREP: begin
          part <= '0;
          cnt  <= CNT_W'(din0_WIDTH - 1);
        end
        S_CALC: begin
          part <= step_rem;
          dvd  <= {dvd[din0_WIDTH-2:0], step_q};
          cnt  <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          div_zero <= zero;
          if (zero) dout <= sign ? QUOT_SAT_NEG : QUOT_SAT_POS;
          else      dout <= sign ? -dvd : dvd;
        end
        default: ;
      endcase
    end
  end

`ifdef FACE_DETECT_DIV_REM_EN
  // Remainder carries the dividend's sign so dividend = q*d + rem holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem <= '0;
    end else if (ce && state == S_FIX) begin
      if (zero) rem <= '0;
      else      rem <= sign ? -part : part;
    end
  end
`else
  assign rem = '0;
`endif

endmodule

// File: tb/tb_face_detect_sdiv_32s_14ns_iter.sv
// Self-checking bench for face_detect_sdiv_32s_14ns_iter against an arithmetic reference model.
module tb_face_detect_sdiv_32s_14ns_iter;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        start;
  logic [31:0] din0;
  logic [13:0] din1;
  logic        ready;
  logic        done;
  logic [31:0] dout;
  logic [14:0] rem;
  logic        div_zero;

  int tests_run    = 0;
  int tests_failed = 0;

  face_detect_sdiv_32s_14ns_iter #(
    .ID(1), .NUM_STAGE(0), .din0_WIDTH(32), .din1_WIDTH(14), .dout_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .ready(ready), .done(done),
    .dout(dout), .rem(rem), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division truncating toward zero; remainder follows the dividend.
  function automatic void model(input logic [31:0] a, input logic [13:0] b,
                                output logic [31:0] q, output logic [14:0] r,
                                output logic z);
    longint sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'(b);
    if (b == 14'd0) begin
      z  = 1'b1;
      q  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      sr = 0;
    end else begin
      z  = 1'b0;
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
    end
`ifdef FACE_DETECT_DIV_REM_EN
    r = sr[14:0];
`else
    r = 15'd0;
`endif
  endfunction

  task automatic launch(input logic [31:0] a, input logic [13:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
  endtask

  task automatic verify_op(input string name, input logic [31:0] a, input logic [13:0] b,
                           input int lat, input int exp_lat);
    logic [31:0] eq;
    logic [14:0] er;
    logic        ez;
    model(a, b, eq, er, ez);
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (dout !== eq) begin
      tests_failed++;
      $display("FAIL %s dout: got %h, expected %h (a=%h b=%0d)", name, dout, eq, a, b);
    end
    tests_run++;
    if (rem !== er) begin
      tests_failed++;
      $display("FAIL %s rem: got %h, expected %h (a=%h b=%0d)", name, rem, er, a, b);
    end
    tests_run++;
    if (div_zero !== ez) begin
      tests_failed++;
      $display("FAIL %s div_zero: got %b, expected %b", name, div_zero, ez);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [13:0] b);
    int n;
    launch(a, b);
    wait_done(n);
    verify_op(name, a, b, n, 34);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    tick();
    tick();
    tests_run++;
    if ({ready, done, dout, rem, div_zero} !== {1'b1, 1'b0, 32'd0, 15'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got ready=%b done=%b dout=%h rem=%h dz=%b, expected 1 0 0 0 0",
               ready, done, dout, rem, div_zero);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op("pos_100_7", 32'd100, 14'd7);
    run_op("neg_100_7", -32'sd100, 14'd7);
    run_op("min_int_1", 32'h8000_0000, 14'd1);
    run_op("zero_pos", 32'd12345, 14'd0);
    run_op("zero_neg", -32'sd5, 14'd0);
    run_op("max_div", 32'h7FFF_FFFF, 14'd16383);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [13:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      if (i % 4 == 1) b = 14'($urandom_range(1, 15));
      run_op($sformatf("rand_%0d", i), a, b);
    end
  endtask

  task automatic test_busy_start();
    int n;
    launch(32'd1000, 14'd3);
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ready: got %b, expected 0", ready);
    end
    din0  = 32'd77;
    din1  = 14'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    verify_op("busy_start", 32'd1000, 14'd3, n + 6, 34);
  endtask

  task automatic test_back_to_back();
    int n;
    launch(32'd5000, 14'd9);
    wait_done(n);
    verify_op("b2b_first", 32'd5000, 14'd9, n, 34);
    launch(-32'sd777777, 14'd1234);
    wait_done(n);
    verify_op("b2b_second", -32'sd777777, 14'd1234, n, 34);
  endtask

  task automatic test_ce_stall();
    int n;
    logic [31:0] held;
    launch(-32'sd123456, 14'd321);
    for (int i = 0; i < 20; i++) tick();
    ce = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    ce = 1'b1;
    wait_done(n);
    verify_op("ce_stall_calc", -32'sd123456, 14'd321, n + 30, 44);
    held = dout;
    ce   = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (done !== 1'b1 || dout !== held) begin
      tests_failed++;
      $display("FAIL ce_stall_done: got done=%b dout=%h, expected done=1 dout=%h", done, dout, held);
    end
    ce = 1'b1;
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse_end: got done=%b, expected 0", done);
    end
    // start with ce low must not be taken
    ce    = 1'b0;
    din0  = 32'd9;
    din1  = 14'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    ce    = 1'b1;
    tick();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ce_low_accept: got ready=%b, expected 1", ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(32'd12345, 14'd7);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({ready, done, dout, rem, div_zero} !== {1'b1, 1'b0, 32'd0, 15'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid: got ready=%b done=%b dout=%h rem=%h dz=%b, expected 1 0 0 0 0",
               ready, done, dout, rem, div_zero);
    end
    tick();
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d done cycles, expected 0", seen);
    end
    run_op("after_reset", 32'd16383, 14'd16383);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
